conn_topk_sorter: RTL and testbench

Consumes the unthrottled connection stream produced by the pairwise distance calculator and keeps the K shortest connections in ascending distance order. After the calculator signals completion, it drains them one per handshake to the downstream circuit-merging logic. It sits between the distance stage and the union-find stage. It is a one-entry-per-cycle insertion sorter with a valid/ready output port.

---
 rtl/aoc_types_pkg.sv | 28 ++
 rtl/topk_slot.sv | 40 ++++
 rtl/conn_topk_sorter.sv | 134 +++++++++++++
 tb/tb_conn_topk_sorter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_types_pkg.sv
// Shared types for the point-connection pipeline: connection record, widths,
// and the top-K sorter state encoding.
package aoc_types_pkg;

  localparam int NUM_POINTS = 1000;
  localparam int DIM_W      = 17;

  // Squared distance of a (DIM_W+1)-bit signed difference, summed over 3 axes.
  function automatic int dist_w(input int dim_w);
    return (dim_w + 1) * 2 + 2;
  endfunction

  localparam int PT_W   = $clog2(NUM_POINTS);
  localparam int DIST_W = dist_w(DIM_W);

  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [PT_W-1:0]   pointa;
    logic [PT_W-1:0]   pointb;
  } conn_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } topk_state_t;

endpackage

// File: rtl/topk_slot.sv
// One cell of the sorted insertion array. Takes the left neighbour on an
// insert ripple, the new entry where it belongs, or the right neighbour on drain.
module topk_slot
  import aoc_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ins_en,
  input  logic  shift_en,
  input  conn_t new_entry,
  input  conn_t left_entry,
  input  logic  left_ins,
  input  conn_t right_entry,
  input  logic  valid,
  output conn_t entry,
  output logic  ins_here
);

  conn_t entry_reg;

  // Strict less-than keeps equal distances in arrival order; an empty slot
  // always accepts, which turns a miss on every valid slot into an append.
  assign ins_here = !valid || (new_entry.distance < entry_reg.distance);
  assign entry    = entry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg <= '0;
    end else if (shift_en) begin
      entry_reg <= right_entry;
    end else if (ins_en) begin
      if (left_ins) begin
        entry_reg <= left_entry;
      end else if (ins_here) begin
        entry_reg <= new_entry;
      end
    end
  end

endmodule

// File: rtl/conn_topk_sorter.sv
// Keeps the K shortest connections sorted ascending while collecting, then
// drains them smallest-first over a valid/ready port.
module conn_topk_sorter
  import aoc_types_pkg::*;
#(
  parameter int NUM_POINTS = 1000,
  parameter int DIM_W      = 17,
  parameter int K          = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  conn_t                  conn,
  input  logic                   conn_vld,
  input  logic                   done,
  output conn_t                  out_conn,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   out_last,
  output logic [$clog2(K+1)-1:0] count,
  output logic                   drained,
  output logic                   err_late
);

  localparam int CNT_W      = $clog2(K + 1);
  localparam int CFG_PT_W   = $clog2(NUM_POINTS);
  localparam int CFG_DIST_W = dist_w(DIM_W);

  // conn_t is fixed by the shared package; a mismatched override is a build error.
  if (CFG_PT_W != PT_W || CFG_DIST_W != DIST_W) begin : g_bad_cfg
    $error("conn_topk_sorter: NUM_POINTS/DIM_W disagree with aoc_types_pkg");
  end

  topk_state_t      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_late_reg;

  conn_t slot_q   [K];
  logic  ins_flag [K];

  logic ins_en;
  logic handshake;
  logic is_full;

  assign out_vld   = (state_reg == DRAIN);
  assign out_last  = out_vld && (count_reg == CNT_W'(1));
  assign out_conn  = slot_q[0];
  assign count     = count_reg;
  assign drained   = (state_reg == DONE);
  assign err_late  = err_late_reg;
  assign ins_en    = (state_reg == COLLECT) && conn_vld;
  assign handshake = out_vld && out_rdy;
  assign is_full   = (count_reg == CNT_W'(K));

  genvar gi;
  for (gi = 0; gi < K; gi++) begin : g_slot
    conn_t left_e;
    conn_t right_e;
    logic  left_f;
    logic  vld;

    if (gi == 0) begin : g_head
      assign left_e = '0;
      assign left_f = 1'b0;
    end else begin : g_body
      assign left_e = slot_q[gi-1];
      assign left_f = ins_flag[gi-1];
    end

    if (gi == K - 1) begin : g_tail
      assign right_e = '0;
    end else begin : g_mid
      assign right_e = slot_q[gi+1];
    end

    assign vld = (CNT_W'(gi) < count_reg);

    topk_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .ins_en     (ins_en),
      .shift_en   (handshake),
      .new_entry  (conn),
      .left_entry (left_e),
      .left_ins   (left_f),
      .right_entry(right_e),
      .valid      (vld),
      .entry      (slot_q[gi]),
      .ins_here   (ins_flag[gi])
    );
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: begin
        if (done && !conn_vld) begin
          state_next = (count_reg != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (handshake && out_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
  end

  // A full array either replaces its tail or drops the beat; size is unchanged.
  always_comb begin
    count_next = count_reg;
    if (ins_en && !is_full) begin
      count_next = count_reg + CNT_W'(1);
    end else if (handshake) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= COLLECT;
      count_reg    <= '0;
      err_late_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (conn_vld && state_reg != COLLECT) begin
        err_late_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conn_topk_sorter.sv
// Directed bench for conn_topk_sorter: table of sort scenarios on K=4 and
// K=3 instances, plus hand-written backpressure, empty/late and reset cases.
module tb_conn_topk_sorter;
  import aoc_types_pkg::*;

  logic  clk;
  logic  rst;
  conn_t conn;
  logic  conn_vld;
  logic  done;
  logic  out_rdy;

  conn_t      oc4, oc3;
  logic       ov4, ov3, ol4, ol3, dr4, dr3, el4, el3;
  logic [2:0] cnt4;
  logic [1:0] cnt3;

  conn_topk_sorter #(.NUM_POINTS(1000), .DIM_W(17), .K(4)) dut4 (
    .clk(clk), .rst(rst), .conn(conn), .conn_vld(conn_vld), .done(done),
    .out_conn(oc4), .out_vld(ov4), .out_rdy(out_rdy), .out_last(ol4),
    .count(cnt4), .drained(dr4), .err_late(el4)
  );

  conn_topk_sorter #(.NUM_POINTS(1000), .DIM_W(17), .K(3)) dut3 (
    .clk(clk), .rst(rst), .conn(conn), .conn_vld(conn_vld), .done(done),
    .out_conn(oc3), .out_vld(ov3), .out_rdy(out_rdy), .out_last(ol3),
    .count(cnt3), .drained(dr3), .err_late(el3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit         use3;
  conn_t      oc;
  logic       ov, ol, dr, el;
  logic [2:0] cnt;

  always_comb begin
    oc  = use3 ? oc3 : oc4;
    ov  = use3 ? ov3 : ov4;
    ol  = use3 ? ol3 : ol4;
    dr  = use3 ? dr3 : dr4;
    el  = use3 ? el3 : el4;
    cnt = use3 ? {1'b0, cnt3} : cnt4;
  end

  int n_vec = 0;
  int n_err = 0;

  localparam int K_RST  = 0;
  localparam int K_IN   = 1;
  localparam int K_DONE = 2;
  localparam int K_OUT  = 3;
  localparam int K_END  = 4;

  typedef struct {
    int kind;
    bit k3;
    int d;
    int a;
    bit last;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int kind, input bit k3, input int d, input int a, input bit last);
    vec_t v;
    v.kind = kind; v.k3 = k3; v.d = d; v.a = a; v.last = last;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; conn_vld = 1'b0; done = 1'b0; out_rdy = 1'b0; conn = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic insert(input int d, input int a);
    conn.distance = DIST_W'(d);
    conn.pointa   = PT_W'(a);
    conn.pointb   = PT_W'(a + 100);
    conn_vld      = 1'b1;
    step();
    conn_vld = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int d, input int a, input bit last);
    chk({tag, ".out_vld"}, longint'(ov), 1);
    chk({tag, ".dist"}, longint'(oc.distance), d);
    chk({tag, ".pointa"}, longint'(oc.pointa), a);
    chk({tag, ".pointb"}, longint'(oc.pointb), a + 100);
    chk({tag, ".out_last"}, longint'(ol), longint'(last));
  endtask

  initial begin
    rst = 1'b0; conn = '0; conn_vld = 1'b0; done = 1'b0; out_rdy = 1'b0; use3 = 1'b0;

    // Basic sort, K=4
    add(K_RST, 0, 0, 0, 0);
    add(K_IN, 0, 50, 1, 0); add(K_IN, 0, 10, 2, 0);
    add(K_IN, 0, 30, 3, 0); add(K_IN, 0, 20, 4, 0);
    add(K_DONE, 0, 4, 0, 0);
    add(K_OUT, 0, 10, 2, 0); add(K_OUT, 0, 20, 4, 0);
    add(K_OUT, 0, 30, 3, 0); add(K_OUT, 0, 50, 1, 1);
    add(K_END, 0, 0, 0, 0);
    // Overflow, K=4: 9 and 100 are discarded
    add(K_RST, 0, 0, 0, 0);
    add(K_IN, 0, 9, 1, 0); add(K_IN, 0, 8, 2, 0); add(K_IN, 0, 7, 3, 0);
    add(K_IN, 0, 6, 4, 0); add(K_IN, 0, 5, 5, 0); add(K_IN, 0, 100, 6, 0);
    add(K_DONE, 0, 4, 0, 0);
    add(K_OUT, 0, 5, 5, 0); add(K_OUT, 0, 6, 4, 0);
    add(K_OUT, 0, 7, 3, 0); add(K_OUT, 0, 8, 2, 1);
    add(K_END, 0, 0, 0, 0);
    // Ties, K=3: equal distance keeps arrival order, tie with full tail drops
    add(K_RST, 1, 0, 0, 0);
    add(K_IN, 1, 7, 1, 0); add(K_IN, 1, 7, 2, 0);
    add(K_IN, 1, 3, 5, 0); add(K_IN, 1, 7, 9, 0);
    add(K_DONE, 1, 3, 0, 0);
    add(K_OUT, 1, 3, 5, 0); add(K_OUT, 1, 7, 1, 0); add(K_OUT, 1, 7, 2, 1);
    add(K_END, 1, 0, 0, 0);

    // Reset state
    do_reset();
    chk("reset.count", longint'(cnt4), 0);
    chk("reset.out_vld", longint'(ov4), 0);
    chk("reset.out_last", longint'(ol4), 0);
    chk("reset.drained", longint'(dr4), 0);
    chk("reset.err_late", longint'(el4), 0);
    chk("reset.out_conn", longint'(oc4.distance) + longint'(oc4.pointa), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].kind)
        K_RST: begin
          use3 = vecs[i].k3;
          do_reset();
        end
        K_IN: begin
          conn.distance = DIST_W'(vecs[i].d);
          conn.pointa   = PT_W'(vecs[i].a);
          conn.pointb   = PT_W'(vecs[i].a + 100);
          conn_vld      = 1'b1;
          step();
        end
        K_DONE: begin
          conn_vld = 1'b0;
          chk($sformatf("v%0d.count", i), longint'(cnt), vecs[i].d);
          chk($sformatf("v%0d.no_vld_yet", i), longint'(ov), 0);
          done = 1'b1; out_rdy = 1'b1;
          step();
        end
        K_OUT: begin
          chk_out($sformatf("v%0d", i), vecs[i].d, vecs[i].a, vecs[i].last);
          step();
        end
        default: begin
          chk($sformatf("v%0d.end_vld", i), longint'(ov), 0);
          chk($sformatf("v%0d.drained", i), longint'(dr), 1);
        end
      endcase
    end

    // Backpressure: hold out_rdy low for 3 cycles after the first handshake
    use3 = 1'b0;
    do_reset();
    insert(40, 1); insert(10, 2); insert(30, 3); insert(20, 4);
    done = 1'b1; out_rdy = 1'b1;
    step();
    chk_out("bp.first", 10, 2, 0);
    step();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_out($sformatf("bp.hold%0d", c), 20, 4, 0);
      chk($sformatf("bp.hold%0d.count", c), longint'(cnt4), 3);
      step();
    end
    out_rdy = 1'b1;
    chk_out("bp.second", 20, 4, 0);
    step();
    chk_out("bp.third", 30, 3, 0);
    step();
    chk_out("bp.fourth", 40, 1, 1);
    step();
    chk("bp.end_vld", longint'(ov4), 0);
    chk("bp.drained", longint'(dr4), 1);
    chk("bp.count", longint'(cnt4), 0);

    // Empty collect, then a late beat
    do_reset();
    done = 1'b1;
    step();
    chk("empty.drained", longint'(dr4), 1);
    chk("empty.out_vld", longint'(ov4), 0);
    chk("empty.err_late0", longint'(el4), 0);
    insert(77, 7);
    chk("late.err_late", longint'(el4), 1);
    chk("late.out_vld", longint'(ov4), 0);
    chk("late.count", longint'(cnt4), 0);

    // Reset in the middle of a drain
    do_reset();
    insert(40, 1); insert(10, 2); insert(30, 3); insert(20, 4);
    done = 1'b1; out_rdy = 1'b1;
    step();
    chk_out("mid.first", 10, 2, 0);
    step();
    chk_out("mid.second", 20, 4, 0);
    step();
    rst = 1'b1; done = 1'b0;
    step();
    rst = 1'b0;
    chk("mid.count", longint'(cnt4), 0);
    chk("mid.out_vld", longint'(ov4), 0);
    chk("mid.drained", longint'(dr4), 0);
    chk("mid.out_conn", longint'(oc4.distance), 0);
    insert(25, 5); insert(15, 6);
    chk("mid.count2", longint'(cnt4), 2);
    done = 1'b1;
    step();
    chk_out("mid.re1", 15, 6, 0);
    step();
    chk_out("mid.re2", 25, 5, 1);
    step();
    chk("mid.redrained", longint'(dr4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
